// File: rtl/pll_dyn_phase_ctrl_if.sv
// rtl/pll_dyn_phase_ctrl_if.sv - setting request handshake into the rPLL dynamic phase controller
`timescale 1ns/1ps
interface pll_dyn_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_psda;
  logic [3:0] req_dutyda;
  logic [3:0] req_fdly;

  modport master (
    output req_valid,
    output req_psda,
    output req_dutyda,
    output req_fdly,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_psda,
    input  req_dutyda,
    input  req_fdly,
    output req_ready
  );
endinterface

// File: rtl/pll_dyn_phase_ctrl.sv
// rtl/pll_dyn_phase_ctrl.sv - drives GW2A rPLL PSDA/DUTYDA/FDLY and supervises LOCK
// Optional PLL_CTRL_LOSS_CNT_EN adds loss_cnt, counting unsolicited lock losses seen in IDLE.
`timescale 1ns/1ps
module pll_dyn_phase_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int RST_CYCLES    = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pll_dyn_phase_ctrl_if.slave  req,
  input  logic                 pll_lock,
  output logic [3:0]           psda,
  output logic [3:0]           dutyda,
  output logic [3:0]           fdly,
  output logic                 pll_reset,
  output logic                 locked,
  output logic                 busy,
  output logic                 err_timeout
`ifdef PLL_CTRL_LOSS_CNT_EN
  ,
  output logic [7:0]           loss_cnt
`endif
);

  localparam int MAX_SL  = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_SL > RST_CYCLES) ? MAX_SL : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);

  localparam logic [3:0] PSDA_RST   = 4'd0;
  localparam logic [3:0] DUTYDA_RST = 4'b1000;
  localparam logic [3:0] FDLY_RST   = 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    WAIT_LOCK,
    PRST
  } state_t;

  state_t                 state_q;
  state_t                 state_n;
  logic [CW-1:0]          cnt_q;
  logic                   cnt_clr;
  logic                   timeout;
  logic                   take;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [3:0]             cap_psda;
  logic [3:0]             cap_dutyda;
  logic [3:0]             cap_fdly;

  // pll_lock is asynchronous to clk; only the last stage is ever looked at
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_clr = 1'b0;
    timeout = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lock_s) begin
          state_n = PRST;
          cnt_clr = 1'b1;
        end else if (req.req_valid) begin
          state_n = APPLY;
          take    = 1'b1;
        end
      end
      APPLY: begin
        state_n = SETTLE;
        cnt_clr = 1'b1;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_n = WAIT_LOCK;
          cnt_clr = 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_n = PRST;
          cnt_clr = 1'b1;
          timeout = 1'b1;
        end
      end
      PRST: begin
        if (cnt_q == RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // One counter serves SETTLE, WAIT_LOCK and PRST; it is cleared on every entry and saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_psda   <= PSDA_RST;
      cap_dutyda <= DUTYDA_RST;
      cap_fdly   <= FDLY_RST;
    end else if (take) begin
      cap_psda   <= req.req_psda;
      cap_dutyda <= req.req_dutyda;
      cap_fdly   <= req.req_fdly;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psda   <= PSDA_RST;
      dutyda <= DUTYDA_RST;
      fdly   <= FDLY_RST;
    end else if (state_q == APPLY) begin
      psda   <= cap_psda;
      dutyda <= cap_dutyda;
      fdly   <= cap_fdly;
    end
  end

  // Registered so the PLL reset pin never sees a decode glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pll_reset   <= (state_n == PRST);
      err_timeout <= timeout;
    end
  end

  assign req.req_ready = (state_q == IDLE) && lock_s;
  assign locked        = (state_q == IDLE) && lock_s;
  assign busy          = (state_q != IDLE);

`ifdef PLL_CTRL_LOSS_CNT_EN
  logic loss;

  assign loss = (state_q == IDLE) && !lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= 8'd0;
    end else if (loss && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_dyn_phase_ctrl.sv
// tb/tb_pll_dyn_phase_ctrl.sv - scoreboard bench for pll_dyn_phase_ctrl
// Also checks loss_cnt when built with PLL_CTRL_LOSS_CNT_EN.
`timescale 1ns/1ps
module tb_pll_dyn_phase_ctrl;
  localparam int SETTLE = 4;
  localparam int TMO    = 20;
  localparam int RSTC   = 8;
  localparam int SYNC   = 2;

  localparam int K_HS       = 0;
  localparam int K_CODE     = 1;
  localparam int K_LOCK     = 2;
  localparam int K_TMO      = 3;
  localparam int K_PRST_ON  = 4;
  localparam int K_PRST_OFF = 5;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic [3:0] fdly;
  logic       pll_reset;
  logic       locked;
  logic       busy;
  logic       err_timeout;
`ifdef PLL_CTRL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  pll_dyn_phase_ctrl_if req_if ();

  pll_dyn_phase_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (TMO),
    .RST_CYCLES    (RSTC),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_if),
    .pll_lock    (pll_lock),
    .psda        (psda),
    .dutyda      (dutyda),
    .fdly        (fdly),
    .pll_reset   (pll_reset),
    .locked      (locked),
    .busy        (busy),
    .err_timeout (err_timeout)
`ifdef PLL_CTRL_LOSS_CNT_EN
    ,
    .loss_cnt    (loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Cycle k = after the k-th rising edge since the last rst_n release
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  function automatic string kname(int k);
    case (k)
      K_HS:       return "handshake";
      K_CODE:     return "codes";
      K_LOCK:     return "locked_rise";
      K_TMO:      return "err_timeout";
      K_PRST_ON:  return "pll_reset_rise";
      K_PRST_OFF: return "pll_reset_fall";
      default:    return "unknown";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c, input int v);
    exp_q.push_back('{kind, c, v});
  endtask

  task automatic observe(input int kind, input int v);
    int idx;
    idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == kind) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL %s actual cycle=%0d val=%0h required none", kname(kind), cyc, v);
    end else begin
      if (exp_q[idx].cyc != cyc || exp_q[idx].val != v) begin
        errors++;
        $display("FAIL %s actual cycle=%0d val=%0h required cycle=%0d val=%0h",
                 kname(kind), cyc, v, exp_q[idx].cyc, exp_q[idx].val);
      end
      exp_q.delete(idx);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_psda"}, int'(psda), 0);
    chk({tag, "_dutyda"}, int'(dutyda), 8);
    chk({tag, "_fdly"}, int'(fdly), 0);
    chk({tag, "_pll_reset"}, int'(pll_reset), 0);
    chk({tag, "_req_ready"}, int'(req_if.req_ready), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_err_timeout"}, int'(err_timeout), 0);
`ifdef PLL_CTRL_LOSS_CNT_EN
    chk({tag, "_loss_cnt"}, int'(loss_cnt), 0);
`endif
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_req(input logic v, input logic [3:0] p, input logic [3:0] d, input logic [3:0] f);
    req_if.req_valid  = v;
    req_if.req_psda   = p;
    req_if.req_dutyda = d;
    req_if.req_fdly   = f;
  endtask

  // Monitor: every output event pops its matching expectation
  initial begin
    logic [11:0] prev_code;
    logic        prev_locked;
    logic        prev_prst;
    prev_code   = 12'h080;
    prev_locked = 1'b0;
    prev_prst   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_if.req_valid && req_if.req_ready)
          observe(K_HS, int'({req_if.req_psda, req_if.req_dutyda, req_if.req_fdly}));
        if ({psda, dutyda, fdly} != prev_code) observe(K_CODE, int'({psda, dutyda, fdly}));
        if (locked && !prev_locked) observe(K_LOCK, 0);
        if (err_timeout) observe(K_TMO, 0);
        if (pll_reset && !prev_prst) observe(K_PRST_ON, 0);
        if (!pll_reset && prev_prst) observe(K_PRST_OFF, 0);
      end
      prev_code   = {psda, dutyda, fdly};
      prev_locked = locked;
      prev_prst   = pll_reset;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(1'b0, 4'd0, 4'd0, 4'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // T1 startup: lock at cycle 10 -> locked at 10+SYNC+1
    to_cycle(10);
    pll_lock = 1'b1;
    expect_ev(K_LOCK, 13, 0);
    to_cycle(14);
    chk("t1_ready", int'(req_if.req_ready), 1);
    chk("t1_busy", int'(busy), 0);
    chk("t1_codes", int'({psda, dutyda, fdly}), 'h080);

    // T2 request: codes two cycles after handshake, locked after settle+1
    to_cycle(16);
    drive_req(1'b1, 4'd5, 4'd6, 4'd3);
    expect_ev(K_HS, 16, 'h563);
    expect_ev(K_CODE, 18, 'h563);
    expect_ev(K_LOCK, 16 + 2 + SETTLE + 1, 0);
    to_cycle(17);
    drive_req(1'b0, 4'd0, 4'd0, 4'd0);
    chk("t2_busy", int'(busy), 1);

    // T3 back-pressure: second request waits for IDLE and wins
    to_cycle(26);
    drive_req(1'b1, 4'd1, 4'd2, 4'd3);
    expect_ev(K_HS, 26, 'h123);
    expect_ev(K_CODE, 28, 'h123);
    expect_ev(K_LOCK, 33, 0);
    to_cycle(27);
    drive_req(1'b1, 4'd9, 4'd10, 4'd11);
    expect_ev(K_HS, 33, 'h9AB);
    expect_ev(K_CODE, 35, 'h9AB);
    expect_ev(K_LOCK, 40, 0);
    to_cycle(30);
    chk("t3_ready_busy", int'(req_if.req_ready), 0);
    to_cycle(34);
    drive_req(1'b0, 4'd0, 4'd0, 4'd0);
    to_cycle(42);
    chk("t3_codes", int'({psda, dutyda, fdly}), 'h9AB);

    // T5 lock loss in IDLE, then T4 timeout with lock stuck low
    to_cycle(44);
    pll_lock = 1'b0;
    expect_ev(K_PRST_ON, 47, 0);
    expect_ev(K_PRST_OFF, 47 + RSTC, 0);
    expect_ev(K_TMO, 55 + TMO, 0);
    expect_ev(K_PRST_ON, 75, 0);
    expect_ev(K_PRST_OFF, 75 + RSTC, 0);
    to_cycle(46);
    drive_req(1'b1, 4'd15, 4'd15, 4'd15);
    chk("t5_ready_lost", int'(req_if.req_ready), 0);
    to_cycle(47);
    drive_req(1'b0, 4'd0, 4'd0, 4'd0);
    to_cycle(50);
    chk("t5_pll_reset", int'(pll_reset), 1);
    chk("t5_busy", int'(busy), 1);
    to_cycle(85);
    pll_lock = 1'b1;
    expect_ev(K_LOCK, 88, 0);
    to_cycle(89);
    chk("t4_codes_kept", int'({psda, dutyda, fdly}), 'h9AB);
`ifdef PLL_CTRL_LOSS_CNT_EN
    chk("t5_loss_cnt", int'(loss_cnt), 1);
`endif

    // T6 reset during SETTLE
    to_cycle(90);
    drive_req(1'b1, 4'd7, 4'd7, 4'd7);
    expect_ev(K_HS, 90, 'h777);
    expect_ev(K_CODE, 92, 'h777);
    to_cycle(91);
    drive_req(1'b0, 4'd0, 4'd0, 4'd0);
    to_cycle(93);
    chk("t6_settle_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset("t6_settle");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_ev(K_LOCK, 3, 0);

    // T6 reset during PRST
    to_cycle(5);
    pll_lock = 1'b0;
    expect_ev(K_PRST_ON, 8, 0);
    to_cycle(10);
    chk("t6_prst_on", int'(pll_reset), 1);
    rst_n = 1'b0;
    #1;
    check_reset("t6_prst");
    pll_lock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_ev(K_LOCK, 3, 0);
    to_cycle(8);

    chk("pending_events", exp_q.size(), 0);
    foreach (exp_q[i])
      $display("  pending %s cycle=%0d val=%0h", kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
